// File: rtl/seq_det_pkg.sv
// Shared elaboration-time helpers for the parameterised serial sequence detector:
// state width and the KMP next-state computation used to build the transition table.
package seq_det_pkg;

  localparam int MAX_PAT_LEN = 16;
  localparam int MAX_CNT_W   = 32;

  // Width able to hold a prefix length 0..pat_len.
  function automatic int state_w(input int pat_len);
    return (pat_len < 2) ? 1 : $clog2(pat_len + 1);
  endfunction

  function automatic logic pat_bit(input logic [15:0] pat, input int idx);
    logic [3:0] sel;
    sel = idx[3:0];
    return pat[sel];
  endfunction

  // Next matched-prefix length after seeing bit b in state s. Text = first s pattern
  // bits followed by b; result = longest proper prefix of the pattern that is a suffix
  // of that text. A full match in non-overlapping mode restarts from zero.
  function automatic int kmp_next(input logic [15:0] pat, input int len, input int s,
                                  input logic b, input logic overlap);
    int  n;
    int  best;
    int  p;
    logic tbit;
    logic ok;
    if (!overlap && (s == len - 1) && (b == pat[0])) return 0;
    n    = s + 1;
    best = 0;
    for (int k = 1; k < len; k++) begin
      if (k <= n) begin
        ok = 1'b1;
        for (int j = 0; j < k; j++) begin
          p    = n - k + j;
          tbit = (p == s) ? b : pat_bit(pat, len - 1 - p);
          if (tbit != pat_bit(pat, len - 1 - j)) ok = 1'b0;
        end
        if (ok) best = k;
      end
    end
    return best;
  endfunction

endpackage

// File: rtl/param_seq_detector_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter
  import seq_det_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  if (W < 1 || W > MAX_CNT_W) begin : g_bad_w
    $error("sat_counter: W must be in 1..32");
  end

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/param_seq_detector.sv
// Serial bit-pattern detector: state is the matched-prefix length, advanced through a
// KMP transition table built from PATTERN at elaboration; Mealy or registered output.
module param_seq_detector
  import seq_det_pkg::*;
#(
  parameter int               PAT_LEN = 5,
  parameter logic [PAT_LEN-1:0] PATTERN = 5'b11011,
  parameter bit               OVERLAP = 1'b1,
  parameter bit               MOORE   = 1'b0,
  parameter int               CNT_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic                         in,
  input  logic                         clear,
  output logic                         out,
  output logic [CNT_W-1:0]             match_count,
  output logic [$clog2(PAT_LEN+1)-1:0] prefix_len
);

  if (PAT_LEN < 2 || PAT_LEN > MAX_PAT_LEN) begin : g_bad_len
    $error("param_seq_detector: PAT_LEN must be in 2..16");
  end
  if (CNT_W < 1 || CNT_W > MAX_CNT_W) begin : g_bad_cnt
    $error("param_seq_detector: CNT_W must be in 1..32");
  end

  localparam int SW = state_w(PAT_LEN);

  logic [SW-1:0] s_q;
  logic [SW-1:0] s_d;
  logic [SW-1:0] nxt;
  logic [SW-1:0] nxt_tbl [PAT_LEN][2];
  logic          match;

  for (genvar gs = 0; gs < PAT_LEN; gs++) begin : g_tbl
    for (genvar gb = 0; gb < 2; gb++) begin : g_bit
      localparam int NXT = kmp_next(16'(PATTERN), PAT_LEN, gs, 1'(gb), OVERLAP);
      assign nxt_tbl[gs][gb] = SW'(NXT);
    end
  end

  // A match needs the last pattern bit while in the final state; clear discards it.
  assign match = in_valid & ~clear & (s_q == SW'(PAT_LEN - 1)) & (in == PATTERN[0]);

  always_comb begin
    nxt = '0;
    for (int i = 0; i < PAT_LEN; i++) begin
      if (s_q == SW'(i)) nxt = in ? nxt_tbl[i][1] : nxt_tbl[i][0];
    end
    s_d = s_q;
    if (clear) begin
      s_d = '0;
    end else if (in_valid) begin
      s_d = nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) s_q <= '0;
    else     s_q <= s_d;
  end

  if (MOORE) begin : g_moore
    logic out_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) out_q <= 1'b0;
      else     out_q <= match;
    end
    assign out = out_q;
  end else begin : g_mealy
    assign out = match & ~rst;
  end

  sat_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clear),
    .inc   (match),
    .count (match_count)
  );

  assign prefix_len = s_q;

endmodule

// File: doc/param_seq_detector.md
PARAM_SEQ_DETECTOR -- requirements
Module: param_seq_detector

Interface
REQ-001 Parameter PAT_LEN, default 5: pattern length in bits, legal range 2..16.
REQ-002 Parameter PATTERN, default 5'b11011: PAT_LEN-bit pattern, bit PAT_LEN-1 is the first bit expected.
REQ-003 Parameter OVERLAP, default 1: 1 = overlapping detection, 0 = non-overlapping.
REQ-004 Parameter MOORE, default 0: 0 = Mealy output, 1 = Moore (registered) output.
REQ-005 Parameter CNT_W, default 8: match counter width, legal range 1..32.
REQ-006 clk  input  1  single clock; all state updates on the rising edge.
REQ-007 rst  input  1  reset, asynchronous and active-high.
REQ-008 in_valid  input  1  qualifies in; the bit is consumed only when in_valid=1.
REQ-009 in  input  1  serial data bit.
REQ-010 clear  input  1  synchronous clear of match state and counter.
REQ-011 out  output  1  detection pulse.
REQ-012 match_count  output  CNT_W  saturating count of detections since reset/clear.
REQ-013 prefix_len  output  $clog2(PAT_LEN+1)  current matched-prefix length, debug.

Function
REQ-014 The state s SHALL be the matched-prefix length, 0..PAT_LEN-1, held in a register.
REQ-015 On a consumed bit, the expected bit SHALL be PATTERN[PAT_LEN-1-s].
- Equal and s+1<PAT_LEN: s <= s+1.
- Equal and s+1==PAT_LEN: match; s <= OVERLAP ? border(PAT_LEN) : 0, where border(k) is the longest proper prefix of PATTERN that is also a suffix of its first k bits.
- Not equal: s SHALL take the KMP transition, i.e. the longest prefix of PATTERN that is a suffix of (matched prefix followed by in), possibly 0.
REQ-016 With in_valid=0, s, out (Moore) and match_count SHALL hold, and no match is generated.
REQ-017 MOORE=0: out SHALL be combinational, out = in_valid & (s==PAT_LEN-1) & (in==PATTERN[0]) & ~clear, with zero-cycle latency.
REQ-018 MOORE=1: out SHALL be registered; it is 1 for exactly the one cycle after the edge where the match bit is consumed, and 0 otherwise.
REQ-019 match_count SHALL increment by 1 on each match edge, saturate at 2^CNT_W-1, and never wrap.
REQ-020 clear=1 SHALL set s=0, match_count=0 and registered out=0 on the next edge; clear wins over a simultaneous match, which is discarded.
REQ-021 A consumed bit in the same cycle as clear SHALL be discarded and not fed into the state.
REQ-022 The next-state table SHALL be derived from PATTERN at elaboration time; no runtime table loading.

Reset
REQ-023 rst=1 SHALL immediately force s=0, registered out=0 and match_count=0, regardless of clk.
REQ-024 A partial match in progress at reset SHALL be lost; detection after rst deasserts restarts from s=0.
REQ-025 Mealy out SHALL be 0 while rst=1.

Structure
REQ-026 A package seq_det_pkg SHALL hold the elaboration-time function computing border/next-state values from (PATTERN, PAT_LEN) and the state-width helper constant.
REQ-027 One sub-module, sat_counter (parameter W; ports clk, rst, clr, inc, count), SHALL implement match_count.
REQ-028 Illegal PAT_LEN or CNT_W values SHALL raise an elaboration error.

Verification
REQ-029 Defaults, OVERLAP=1, MOORE=0, stream 1,1,0,1,1,0,1,1 all valid -> out=1 combinationally on bits 5 and 8; match_count=2.
REQ-030 Same stream, OVERLAP=0 -> out=1 on bit 5 only; match_count=1.
REQ-031 MOORE=1, stream 1,1,0,1,1 -> out=1 for one cycle after the 5th-bit edge; 0 on every other cycle.
REQ-032 Stream 1,1,0,1, rst pulsed between clock edges, then 1 -> no match; out=0, match_count=0, prefix_len=1.
REQ-033 Stream 1,1 then 3 cycles with in_valid=0 (in toggling), then 0,1,1 -> exactly one match; prefix_len holds at 2 during the gap.
REQ-034 CNT_W=2, 5 non-overlapping matches -> match_count=3; then clear asserted on a match cycle -> match_count=0, no out pulse (Moore).
